// File: rtl/inv_key_schedule.sv
// AES-128 key expansion holding all 11 round keys for inverse-cipher readout.
// Latency: 10 cycles from key_load to key_ready; subkey lags round_idx by 1 cycle.
// No backpressure: key_load restarts expansion at any time; reads are free-running.
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [3:0]   round_idx,
    output logic [127:0] subkey,
    output logic         key_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } state_t;

    // Forward S-box, byte 0 in the top bits.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] prev,
                                                    input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;
        w0  = prev[127:96];
        w1  = prev[95:64];
        w2  = prev[63:32];
        w3  = prev[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0  = w0 ^ sub ^ {rc, 24'h000000};
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   subkey_q, subkey_d;
    logic           key_ready_q, key_ready_d;
    logic [127:0]   rk_q [0:10];
    logic [127:0]   rk_d [0:10];
    logic [127:0]   prev_rk;
    logic [127:0]   next_rk;
    logic [127:0]   rd_rk;

    always_comb begin
        prev_rk = '0;
        if (cnt_q >= 4'd1 && cnt_q <= 4'd10) begin
            prev_rk = rk_q[cnt_q - 4'd1];
        end
        next_rk = next_round_key(prev_rk, rcon(cnt_q));
    end

    always_comb begin
        rd_rk = '0;
        if (round_idx <= 4'd10) begin
            rd_rk = rk_q[round_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        subkey_d    = '0;
        key_ready_d = 1'b0;
        rk_d        = rk_q;
        if (key_load) begin
            rk_d[0] = key_in;
            cnt_d   = 4'd1;
            state_d = ST_EXPAND;
        end else begin
            case (state_q)
                ST_EXPAND: begin
                    if (cnt_q >= 4'd1 && cnt_q <= 4'd10) begin
                        rk_d[cnt_q] = next_rk;
                    end
                    if (cnt_q >= 4'd10) begin
                        state_d     = ST_READY;
                        key_ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_READY: begin
                    key_ready_d = 1'b1;
                    subkey_d    = rd_rk;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            subkey_q    <= '0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            subkey_q    <= subkey_d;
            key_ready_q <= key_ready_d;
        end
    end

    // Key storage is never exposed outside READY, so it carries no reset.
    always_ff @(posedge clk) begin
        rk_q <= rk_d;
    end

    assign subkey    = subkey_q;
    assign key_ready = key_ready_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule with an independent key-expansion model
// and a queue scoreboard for subkey reads.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic [3:0]   round_idx;
    logic [127:0] subkey;
    logic         key_ready;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] mdl [0:10];
    logic [127:0] exp_q [$];

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    inv_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_load  (key_load),
        .round_idx (round_idx),
        .subkey    (subkey),
        .key_ready (key_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    // S-box from GF(2^8) inverse plus affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] xb  = 8'(x);
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboarded read: expectation queued at drive time, checked when subkey updates.
    task automatic read_idx(input logic [3:0] idx, input logic [127:0] expv, input string tag);
        round_idx = idx;
        exp_q.push_back(expv);
        step();
        check(tag, subkey, exp_q.pop_front());
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    // Cycles until key_ready rises, or -1 if it never does within the budget.
    task automatic wait_ready(output int n);
        n = -1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (key_ready === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic [127:0] key_c;
        rst       = 1'b1;
        key_in    = '0;
        key_load  = 1'b0;
        round_idx = 4'd0;
        build_sbox();
        step();
        step();
        rst = 1'b0;
        check("reset_key_ready", 128'(key_ready), 128'd0);
        check("reset_subkey", subkey, 128'd0);
        read_idx(4'd0, 128'd0, "read_before_load");
        check("ready_before_load", 128'(key_ready), 128'd0);

        // Key A: latency and the two published round keys.
        load_key(KEY_A);
        check("ready_low_after_load", 128'(key_ready), 128'd0);
        wait_ready(n);
        check("latency_key_a", 128'(n), 128'd10);
        check("subkey_zero_at_ready", subkey, 128'd0);
        read_idx(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "key_a_rk1");
        read_idx(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "key_a_rk10");
        model_expand(KEY_A);
        read_idx(4'd5, mdl[5], "key_a_rk5");

        // Key B: decryption-order sweep.
        load_key(KEY_B);
        wait_ready(n);
        check("latency_key_b", 128'(n), 128'd10);
        model_expand(KEY_B);
        read_idx(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "key_b_rk10");
        for (int i = 9; i >= 1; i--) read_idx(4'(i), mdl[i], $sformatf("key_b_rk%0d", i));
        read_idx(4'd0, KEY_B, "key_b_rk0");

        // Out-of-range indices, then persistence of stored keys.
        read_idx(4'd11, 128'd0, "idx11_zero");
        read_idx(4'd15, 128'd0, "idx15_zero");
        read_idx(4'd7, mdl[7], "key_b_rk7_reread");
        check("ready_held", 128'(key_ready), 128'd1);

        // Reload mid-expansion: only the second key may survive.
        key_c = {$urandom, $urandom, $urandom, $urandom};
        load_key(KEY_A);
        for (int i = 0; i < 4; i++) step();
        check("ready_low_mid_expand", 128'(key_ready), 128'd0);
        load_key(key_c);
        wait_ready(n);
        check("latency_reload", 128'(n), 128'd10);
        model_expand(key_c);
        for (int i = 10; i >= 0; i--) read_idx(4'(i), mdl[i], $sformatf("key_c_rk%0d", i));

        // Reset at cycle 4 of expansion.
        load_key(KEY_A);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_expand_ready", 128'(key_ready), 128'd0);
        check("rst_expand_subkey", subkey, 128'd0);
        for (int i = 0; i < 15; i++) step();
        check("rst_expand_stays_low", 128'(key_ready), 128'd0);
        read_idx(4'd1, 128'd0, "rst_expand_read");

        // Reset while READY.
        load_key(KEY_A);
        wait_ready(n);
        check("latency_after_rst", 128'(n), 128'd10);
        round_idx = 4'd3;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ready_ready", 128'(key_ready), 128'd0);
        check("rst_ready_subkey", subkey, 128'd0);
        read_idx(4'd3, 128'd0, "rst_ready_read");

        // Reset together with key_load: the load must be ignored.
        key_in   = KEY_B;
        key_load = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        key_load = 1'b0;
        check("rst_load_ready", 128'(key_ready), 128'd0);
        check("rst_load_subkey", subkey, 128'd0);
        for (int i = 0; i < 15; i++) step();
        check("rst_load_ignored", 128'(key_ready), 128'd0);
        read_idx(4'd0, 128'd0, "rst_load_read");

        // Normal operation after the resets.
        load_key(KEY_B);
        wait_ready(n);
        check("latency_final", 128'(n), 128'd10);
        model_expand(KEY_B);
        read_idx(4'd3, mdl[3], "final_rk3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL expose port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-003 The block SHALL expose port key_in, input, 128 bits, the AES-128 cipher key; bits [127:96] are word w0 and bits [31:0] are word w3.
REQ-004 The block SHALL expose port key_load, input, 1 bit, a one-cycle request to capture key_in and start expansion.
REQ-005 The block SHALL expose port round_idx, input, 4 bits, the round-key index requested, valid range 0..10.
REQ-006 The block SHALL expose port subkey, output, 128 bits, a registered round key that feeds the subkey input of the inverse add-round-key stage.
REQ-007 The block SHALL expose port key_ready, output, 1 bit, high while all 11 round keys are valid and subkey reflects round_idx.

Function
REQ-008 The block SHALL implement a three-state FSM: IDLE (no key held), EXPAND (generating keys), READY (keys valid).
REQ-009 When key_load is sampled high in any state, the block SHALL write key_in to rk[0], set the round counter to 1, enter EXPAND and drive key_ready low from the next cycle.
REQ-010 A key_load sampled high during EXPAND SHALL abort the current expansion and restart it from the new key_in, per REQ-009.
REQ-011 In EXPAND, the block SHALL compute exactly one round key per cycle: rk[n] from rk[n-1] using RotWord, SubWord (AES forward S-box) and Rcon[n], per FIPS-197.
REQ-012 The Rcon sequence for n=1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word.
REQ-013 The first word of rk[n] SHALL be w(n-1,0) XOR SubWord(RotWord(w(n-1,3))) XOR Rcon[n].
REQ-014 For j=1..3, word j of rk[n] SHALL be w(n,j-1) XOR w(n-1,j).
REQ-015 When rk[10] is written (counter=10), the FSM SHALL enter READY and key_ready SHALL be high from the following cycle.
REQ-016 With key_load sampled at edge T0, rk[1]..rk[10] SHALL be written at edges T1..T10 and key_ready SHALL be high after edge T10, a latency of 10 cycles.
REQ-017 In READY, subkey SHALL register rk[round_idx] on every edge, giving a 1-cycle read latency.
REQ-018 In READY, if round_idx > 10, subkey SHALL be registered as 0.
REQ-019 In IDLE or EXPAND, subkey SHALL be registered as 0.
REQ-020 key_ready SHALL never be high in the same cycle as subkey derived from a partially expanded key.
REQ-021 Stored round keys SHALL persist in READY until the next key_load or rst, so any index can be read any number of times in any order (decryption reads 10 down to 0).

Reset
REQ-022 On rst sampled high, the FSM SHALL go to IDLE, the counter SHALL clear to 0, and key_ready and subkey SHALL be 0 after that edge.
REQ-023 rst SHALL take priority over a simultaneous key_load, which is then ignored.
REQ-024 rst asserted mid-EXPAND or in READY SHALL abort operation; key_ready SHALL stay low until a new expansion completes.
REQ-025 The rk storage contents need not be cleared by reset, but SHALL never be visible on subkey unless key_ready is high.

Verification
REQ-026 Load key_in=2b7e151628aed2a6abf7158809cf4f3c -> key_ready high exactly 10 cycles after load; round_idx=1 gives subkey=a0fafe1788542cb123a339392a6c7605 and round_idx=10 gives subkey=d014f9a8c9ee2589e13f0cc8b6630ca6, each one cycle later.
REQ-027 Load key_in=000102030405060708090a0b0c0d0e0f, then sweep round_idx 10 down to 0 -> subkey at index 10 is 13111d7fe3944a17f307a78b4d2b30c5 and at index 0 is 000102030405060708090a0b0c0d0e0f, one cycle after each index.
REQ-028 Reload with the second key at cycle 5 of the first expansion -> key_ready low until 10 cycles after the reload, and the final keys match the second key only.
REQ-029 Assert rst at cycle 4 of expansion, then at READY, and also together with key_load -> key_ready=0 and subkey=0 after the edge; FSM in IDLE; the simultaneous key_load is ignored.
REQ-030 In READY, drive round_idx=11 and round_idx=15 -> subkey=0; a read before any load -> subkey=0 and key_ready=0.
